// File: rtl/sa_adc_uart_tx.sv
// sa_adc_uart_tx: frames SAR ADC samples into self-synchronising packets and
// sends them out as 8N1 UART. byte0 = {1, s[13:7]}, byte1 = {0, s[6:0]}.
// A one-deep holding buffer takes a sample that arrives while a frame is in
// flight. Further samples are dropped, and a saturating counter counts them.
// Optional build macro SA_ADC_UART_CHECKSUM_EN appends a third byte,
// {0, byte0[6:0] ^ byte1[6:0]}, to every frame.
module sa_adc_uart_tx #(
  parameter int CLKS_PER_BIT = 312,
  parameter int DATA_W       = 14
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_vld_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [7:0]        drop_cnt_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef SA_ADC_UART_CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd2;
`else
  localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Zero-extend a sample on the MSB side to the 14-bit frame payload.
  function automatic logic [13:0] zext(input logic [DATA_W-1:0] d);
    return 14'(d);
  endfunction

`ifdef SA_ADC_UART_CHECKSUM_EN
  // 7-bit XOR checksum over the payload halves carried by byte0 and byte1.
  function automatic logic [6:0] checksum7(input logic [13:0] s);
    return s[13:7] ^ s[6:0];
  endfunction
`endif

  // Select byte idx of the packet built from payload s.
  function automatic logic [7:0] frame_byte(input logic [13:0] s, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {1'b1, s[13:7]};
      2'd1:    b = {1'b0, s[6:0]};
`ifdef SA_ADC_UART_CHECKSUM_EN
      2'd2:    b = {1'b0, checksum7(s)};
`endif
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]  baud_r, baud_nxt_s;
  logic [2:0]        bit_r, bit_nxt_s;
  logic [1:0]        byte_r, byte_nxt_s;
  logic [13:0]       frame_r, frame_nxt_s;
  logic [13:0]       hold_r, hold_nxt_s;
  logic              hold_vld_r, hold_vld_nxt_s;
  logic [7:0]        drop_r, drop_nxt_s;
  logic              tx_r, tx_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              baud_end_s;
  logic              consume_s;
  logic [13:0]       sample_ext_s;
  logic [7:0]        byte_val_s;

  assign sample_ext_s = zext(sample_i);
  assign baud_end_s   = (baud_r == BAUD_LAST);
  // Last cycle of the final stop bit: the holding buffer may be drained here.
  assign consume_s    = (state_r == ST_STOP) && baud_end_s && (byte_r == LAST_BYTE);

  // Frame sequencing: bit timing, byte stepping and frame chaining.
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_r;
    bit_nxt_s   = bit_r;
    byte_nxt_s  = byte_r;
    frame_nxt_s = frame_r;
    case (state_r)
      ST_IDLE: begin
        if (sample_vld_i) begin
          frame_nxt_s = sample_ext_s;
          state_nxt_s = ST_START;
          baud_nxt_s  = '0;
          bit_nxt_s   = 3'd0;
          byte_nxt_s  = 2'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_end_s) begin
          state_nxt_s = ST_DATA;
          baud_nxt_s  = '0;
          bit_nxt_s   = 3'd0;
        end else begin
          baud_nxt_s  = baud_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_end_s) begin
          baud_nxt_s = '0;
          if (bit_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            bit_nxt_s = bit_r + 3'd1;
          end
        end else begin
          baud_nxt_s = baud_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_end_s) begin
          baud_nxt_s = '0;
          bit_nxt_s  = 3'd0;
          if (byte_r != LAST_BYTE) begin
            byte_nxt_s  = byte_r + 2'd1;
            state_nxt_s = ST_START;
          end else if (hold_vld_r) begin
            // Chain the held sample with no idle bit in between.
            frame_nxt_s = hold_r;
            byte_nxt_s  = 2'd0;
            state_nxt_s = ST_START;
          end else if (sample_vld_i) begin
            // Holding is empty: a sample on the closing cycle starts directly.
            frame_nxt_s = sample_ext_s;
            byte_nxt_s  = 2'd0;
            state_nxt_s = ST_START;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          baud_nxt_s = baud_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        baud_nxt_s  = '0;
        bit_nxt_s   = 3'd0;
        byte_nxt_s  = 2'd0;
      end
    endcase
  end

  // Sample acceptance while busy: fill the holding buffer, or count a drop.
  always_comb begin
    hold_nxt_s     = hold_r;
    hold_vld_nxt_s = hold_vld_r;
    drop_nxt_s     = drop_r;
    if (consume_s && hold_vld_r) begin
      hold_vld_nxt_s = 1'b0;
    end else begin
      hold_vld_nxt_s = hold_vld_r;
    end
    if ((state_r != ST_IDLE) && sample_vld_i) begin
      if (consume_s) begin
        if (hold_vld_r) begin
          hold_nxt_s     = sample_ext_s;
          hold_vld_nxt_s = 1'b1;
        end else begin
          hold_nxt_s = hold_r;
        end
      end else if (!hold_vld_r) begin
        hold_nxt_s     = sample_ext_s;
        hold_vld_nxt_s = 1'b1;
      end else if (drop_r != 8'hFF) begin
        drop_nxt_s = drop_r + 8'd1;
      end else begin
        drop_nxt_s = drop_r;
      end
    end else begin
      hold_nxt_s = hold_r;
    end
  end

  // Next output values, derived from the next state so that the outputs are registered.
  always_comb begin
    byte_val_s = frame_byte(frame_nxt_s, byte_nxt_s);
    tx_nxt_s   = 1'b1;
    case (state_nxt_s)
      ST_START: tx_nxt_s = 1'b0;
      ST_DATA:  tx_nxt_s = byte_val_s[bit_nxt_s];
      default:  tx_nxt_s = 1'b1;
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_STOP) && (byte_nxt_s == LAST_BYTE) &&
                 (baud_nxt_s == BAUD_LAST);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= ST_IDLE;
      baud_r     <= '0;
      bit_r      <= 3'd0;
      byte_r     <= 2'd0;
      frame_r    <= 14'd0;
      hold_r     <= 14'd0;
      hold_vld_r <= 1'b0;
      drop_r     <= 8'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      baud_r     <= baud_nxt_s;
      bit_r      <= bit_nxt_s;
      byte_r     <= byte_nxt_s;
      frame_r    <= frame_nxt_s;
      hold_r     <= hold_nxt_s;
      hold_vld_r <= hold_vld_nxt_s;
      drop_r     <= drop_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign tx_o         = tx_r;
  assign busy_o       = busy_r;
  assign frame_done_o = done_r;
  assign drop_cnt_o   = drop_r;

endmodule

// File: tb/tb_sa_adc_uart_tx.sv
// Scoreboard bench for sa_adc_uart_tx. A transaction-level model runs on
// frame end times. It predicts the frame bytes, the frame_done edges, busy
// and the drop count. A negedge monitor decodes the UART line and compares
// every result against the queues.
module tb_sa_adc_uart_tx;
  localparam int CPB = 4;
  localparam int DW  = 14;
`ifdef SA_ADC_UART_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int FB = NB * 10 * CPB;   // frame length in cycles

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sample = '0;
  logic          sample_vld = 1'b0;
  logic          tx, busy, done;
  logic [7:0]    drop;

  sa_adc_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk_i(clk), .reset_i(reset), .sample_i(sample), .sample_vld_i(sample_vld),
    .tx_o(tx), .busy_o(busy), .frame_done_o(done), .drop_cnt_o(drop)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state (edge-indexed)
  int          e = 0;
  bit          m_rst = 1'b0;
  bit          m_act = 1'b0;
  int          m_end = 0;
  int          m_start = -1;
  bit          m_hold_v = 1'b0;
  logic [13:0] m_hold = '0;
  int          m_drop = 0;
  logic [7:0]  exp_bytes[$];
  int          exp_done[$];
  int          req_chk = 0;

  task automatic push_frame(input logic [13:0] s, input int at);
    logic [7:0] b0, b1;
    b0 = 8'(128 + s / 128);
    b1 = 8'(s % 128);
    exp_bytes.push_back(b0);
    exp_bytes.push_back(b1);
`ifdef SA_ADC_UART_CHECKSUM_EN
    exp_bytes.push_back((b0 ^ b1) & 8'h7F);
`endif
    exp_done.push_back(at + FB - 1);
    m_act   = 1'b1;
    m_end   = at + FB;
    m_start = at;
  endtask

  // Model: one step per rising edge, using the inputs the DUT samples there.
  always @(posedge clk) begin
    e = e + 1;
    m_rst = reset;
    if (reset) begin
      m_act = 1'b0; m_hold_v = 1'b0; m_drop = 0; m_start = -1;
      exp_bytes.delete(); exp_done.delete();
    end else if (!m_act) begin
      if (sample_vld) push_frame(14'(sample), e);
    end else if (e == m_end) begin
      if (m_hold_v) begin
        push_frame(m_hold, e);
        m_hold_v = 1'b0;
        if (sample_vld) begin m_hold = 14'(sample); m_hold_v = 1'b1; end
      end else if (sample_vld) begin
        push_frame(14'(sample), e);
      end else begin
        m_act = 1'b0;
      end
    end else if (sample_vld) begin
      if (!m_hold_v) begin m_hold = 14'(sample); m_hold_v = 1'b1; end
      else if (m_drop < 255) m_drop = m_drop + 1;
    end
  end

  // Monitor and UART decoder: all checking happens on the falling edge.
  bit         d_act = 1'b0;
  int         d_cnt = 0;
  int         d_k = 0;
  logic [7:0] d_byte = '0;
  logic [7:0] d_exp;
  int         x_done;
  always @(negedge clk) begin
    if (e > 0) begin
      if (m_rst) begin
        tests++;
        if ({tx, busy, done, drop} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
          fails++;
          $display("FAIL reset_state: got tx=%b busy=%b done=%b drop=%0d, want 1 0 0 0",
                   tx, busy, done, drop);
        end
      end else begin
        if (done === 1'b1) begin
          tests++;
          if (exp_done.size() == 0) begin
            fails++;
            $display("FAIL frame_done: pulse at edge %0d, no frame end expected", e);
          end else begin
            x_done = exp_done.pop_front();
            if (x_done != e) begin
              fails++;
              $display("FAIL frame_done: pulse at edge %0d, want edge %0d", e, x_done);
            end
          end
        end
        tests++;
        if (busy !== m_act || drop !== 8'(m_drop)) begin
          fails++;
          $display("FAIL busy_drop: got busy=%b drop=%0d, want busy=%b drop=%0d",
                   busy, drop, m_act, m_drop);
        end
        if (!m_act || e == m_start) begin
          tests++;
          if (tx !== (m_act ? 1'b0 : 1'b1)) begin
            fails++;
            $display("FAIL tx_level: got %b at edge %0d, want %b", tx, e, m_act ? 1'b0 : 1'b1);
          end
        end
      end
    end
    // UART byte decoding, sampling mid-bit
    if (reset) begin
      d_act = 1'b0;
    end else if (!d_act) begin
      if (tx === 1'b0) begin d_act = 1'b1; d_cnt = 0; end
    end else begin
      d_cnt = d_cnt + 1;
      if (d_cnt % CPB == CPB / 2) begin
        d_k = d_cnt / CPB;
        if (d_k == 0) begin
          tests++;
          if (tx !== 1'b0) begin
            fails++; d_act = 1'b0;
            $display("FAIL start_bit: got %b mid start bit, want 0", tx);
          end
        end else if (d_k <= 8) begin
          d_byte[d_k-1] = tx;
        end else begin
          d_act = 1'b0;
          tests++;
          if (tx !== 1'b1) begin
            fails++;
            $display("FAIL stop_bit: got %b, want 1", tx);
          end
          tests++;
          if (exp_bytes.size() == 0) begin
            fails++;
            $display("FAIL uart_byte: got 0x%02h, no byte expected", d_byte);
          end else begin
            d_exp = exp_bytes.pop_front();
            if (d_byte !== d_exp) begin
              fails++;
              $display("FAIL uart_byte: got 0x%02h, want 0x%02h", d_byte, d_exp);
            end
          end
        end
      end
    end
    // End-of-phase requests from the stimulus process
    if (req_chk == 1) begin
      tests++;
      if (drop !== 8'd255) begin
        fails++;
        $display("FAIL drop_saturate: got %0d, want 255", drop);
      end
    end else if (req_chk == 2) begin
      tests++;
      if (exp_bytes.size() != 0 || exp_done.size() != 0) begin
        fails++;
        $display("FAIL drain: %0d bytes and %0d frame_done pulses still outstanding",
                 exp_bytes.size(), exp_done.size());
      end
    end
  end

  task automatic strobe(input logic [DW-1:0] v);
    sample = v; sample_vld = 1'b1;
    @(posedge clk); #1;
    sample_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (m_act && g < 20 * FB) begin
      @(posedge clk); #1; g++;
    end
    idle(3);
  endtask

  task automatic request(input int code);
    req_chk = code;
    @(negedge clk); #1;
    req_chk = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    // single sample
    strobe(14'h2FFF); drain();
    // extremes
    strobe(14'h0000); drain();
    strobe(14'h3FFF); drain();
    // three strobes inside byte0: hold one, drop one
    strobe(14'h0001); strobe(14'h0002); strobe(14'h0003); drain();
    // strobe on the closing cycle while holding is full
    strobe(14'h0AAA); idle(9); strobe(14'h1555); idle(FB - 11); strobe(14'h0F0F); drain();
    request(2);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      sample     = DW'($urandom);
      sample_vld = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    sample_vld = 1'b0;
    drain();
    request(2);
    // 300 back-to-back strobes saturate the drop counter
    for (int i = 0; i < 300; i++) begin
      sample = DW'($urandom); sample_vld = 1'b1;
      @(posedge clk); #1;
    end
    sample_vld = 1'b0;
    request(1);
    drain();
    request(1);
    // reset in the middle of byte0, then a clean frame
    strobe(DW'($urandom)); idle(10);
    reset = 1'b1; idle(2);
    reset = 1'b0; idle(2);
    strobe(14'h1234); drain();
    request(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
